ram_access: RTL and testbench
=============================

// Module: ram_access
// PURPOSE
//  Byte-addressed 512x8 data memory with a word-wide access port.
//  Serves byte, halfword and word reads/writes, big-endian, over an Enable/MOC
//  (memory-operation-complete) handshake.
//  Sits between the CPU datapath/control unit and storage; doubleword accesses
//  are issued by the client as two word accesses.
// PARAMETERS
//  ADDR_W   9   byte-address width; depth = 2**ADDR_W bytes
//  DATA_W   32  DataIn/DataOut width
//  LATENCY  2   clk cycles from request accept to MOC (legal range 1..15)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  Enable     in   1       request strobe; high = request/hold, low = release
//  ReadWrite  in   1       1 = read, 0 = write
//  Address    in   ADDR_W  byte address of first (most-significant) byte
//  DataIn     in   DATA_W  write data, right-justified for byte/halfword
//  mode       in   4       [1:0] size: 00 byte, 01 halfword, 10 word, 11 reserved; [3:2] ignored
//  DataOut    out  DATA_W  read data, registered, zero-extended
//  MOC        out  1       operation complete
// BEHAVIOUR
//  - FSM IDLE->BUSY->DONE.
//  - IDLE: Enable=1 at a clk edge latches Address, DataIn, mode, ReadWrite; enter BUSY.
//  - BUSY: count LATENCY-1 more edges, then enter DONE and commit the access.
//  - DONE: MOC = (state==DONE) & Enable, combinational, so MOC drops the same
//    instant Enable falls. Enable=0 at an edge -> IDLE. Enable held high keeps DONE
//    (no re-trigger); a new access needs Enable low for >=1 edge.
//  - Big-endian: N = 1/2/4 bytes at addresses A..A+N-1, modulo 2**ADDR_W
//    (wrap 511->0). Unaligned addresses are legal.
//  - Write byte: mem[A]=DataIn[7:0]. Halfword: mem[A]=DataIn[15:8], mem[A+1]=DataIn[7:0].
//    Word: mem[A]=DataIn[31:24] .. mem[A+3]=DataIn[7:0].
//  - Read: DataOut loaded at the DONE entry edge, zero-extended for byte/halfword.
//    Held until the next read commits; unchanged by writes.
//  - Reserved size (11): write suppressed; read returns 0. MOC still completes.
//  - Input changes after accept are ignored until the next IDLE accept.
//  - Reset (any time): state=IDLE, MOC=0, DataOut=0. An access aborted before
//    DONE performs no memory write. Memory contents are not cleared by reset
//    (X at power-up).
// CONFIGURATION
//  RAM_ALIGN_FAULT_EN defined:
//    - adds output Misalign (1 bit). Misalign=1 with MOC for halfword at odd A or
//      word at A[1:0]!=0; such writes are suppressed and reads return 0.
//    - Misalign reset value 0; cleared on next accept.
//  Undefined: no Misalign port, unaligned accesses performed as above.
// STRUCTURE
//  - package ram_access_pkg: size enum (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD),
//    FSM state enum, DEPTH constant.
//  - sub-module ram_byte_array: 2**ADDR_W x 8 storage with 4 byte lanes, each with
//    its own address/we, wrapping address increment. ram_access holds FSM,
//    latency counter, lane steering and DataOut register.
// TESTING
//  - Preload bytes 0..7 = 11,22,..,88 (mode 0 writes); word read @0 -> DataOut=0x11223344,
//    MOC after LATENCY edges.
//  - Halfword write 0xABCD @3, word read @0 -> 0x112233AB; byte read @4 -> 0x000000CD.
//  - Word write 0xDEADBEEF @510; byte reads 510,511,0,1 -> DE,AD,BE,EF (wrap).
//  - Hold Enable high after MOC for 5 cycles -> MOC stays 1, no second access;
//    drop Enable -> MOC=0 immediately.
//  - Assert rst_n=0 during BUSY of a write -> MOC=0, DataOut=0, target bytes unchanged.
//  - mode=3 read -> DataOut=0, MOC=1; with RAM_ALIGN_FAULT_EN, word read @1 -> Misalign=1.

Source files
------------

// File: rtl/ram_access_pkg.sv
// ============================================================================
//  Module : ram_access_pkg
//  Brief  : Shared types and constants for the ram_access data memory.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_access_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;
  localparam int LANES      = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Number of bytes touched by an access; zero for the reserved size.
  function automatic logic [2:0] size_bytes(input size_e sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_byte_array.sv
// ============================================================================
//  Module : ram_byte_array
//  Brief  : 2**ADDR_W x 8 storage with four byte lanes at base+0..base+3,
//           addresses wrapping modulo the depth. Combinational read.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_byte_array
  import ram_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES-1:0]        lane_we,
  input  logic [LANES-1:0][7:0]   lane_wdata,
  output logic [LANES-1:0][7:0]   lane_rdata
);

  localparam int ARR_DEPTH = 2 ** ADDR_W;

  logic [7:0]                     mem [ARR_DEPTH];
  logic [LANES-1:0][ADDR_W-1:0]   lane_addr;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // Natural ADDR_W-bit overflow gives the wrap from the top byte back to 0.
    assign lane_addr[i]  = base_addr + ADDR_W'(i);
    assign lane_rdata[i] = mem[lane_addr[i]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (lane_we[i]) begin
        mem[lane_addr[i]] <= lane_wdata[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_access.sv
// ============================================================================
//  Module : ram_access
//  Brief  : Big-endian byte/halfword/word access port over a byte array with
//           an Enable/MOC handshake. Optional macro RAM_ALIGN_FAULT_EN adds a
//           Misalign output and suppresses unaligned accesses.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_access
  import ram_access_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Enable,
  input  logic              ReadWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [3:0]        mode,
  output logic [DATA_W-1:0] DataOut,
`ifdef RAM_ALIGN_FAULT_EN
  output logic              Misalign,
`endif
  output logic              MOC
);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        din_q, din_d;
  size_e              size_q, size_d;
  logic               rd_q, rd_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               commit;

  logic [ADDR_W-1:0]  acc_addr;
  logic [31:0]        acc_din;
  size_e              acc_size;
  logic               acc_rd;
  logic [2:0]         acc_n;
  logic               acc_bad;
  logic               acc_misalign;
  logic [5:0]         shamt;
  logic               wr_commit;

  logic [LANES-1:0]       lane_we;
  logic [LANES-1:0][7:0]  lane_wdata;
  logic [LANES-1:0][7:0]  lane_rdata;
  logic [31:0]            wdata_left;
  logic [31:0]            rdata_word;
  logic [31:0]            rdata_just;

  logic unused_mode_hi;
  assign unused_mode_hi = ^mode[3:2];

  // With a one-cycle latency the commit happens on the accept edge itself,
  // so the access fields come straight from the ports while idle.
  assign acc_addr = (state_q == ST_IDLE) ? Address       : addr_q;
  assign acc_din  = (state_q == ST_IDLE) ? DataIn[31:0]  : din_q;
  assign acc_size = (state_q == ST_IDLE) ? size_e'(mode[1:0]) : size_q;
  assign acc_rd   = (state_q == ST_IDLE) ? ReadWrite     : rd_q;
  assign acc_n    = size_bytes(acc_size);

`ifdef RAM_ALIGN_FAULT_EN
  assign acc_misalign = ((acc_size == SZ_HALF) && acc_addr[0]) ||
                        ((acc_size == SZ_WORD) && (acc_addr[1:0] != 2'b00));
`else
  assign acc_misalign = 1'b0;
`endif

  assign acc_bad   = (acc_size == SZ_RSVD) || acc_misalign;
  assign wr_commit = commit && !acc_rd && !acc_bad;

  // Left-justify write data so lane 0 always carries the most-significant byte.
  assign shamt      = 6'd32 - {acc_n, 3'b000};
  assign wdata_left = acc_din << shamt;
  assign rdata_word = {lane_rdata[0], lane_rdata[1], lane_rdata[2], lane_rdata[3]};
  assign rdata_just = rdata_word >> shamt;

  for (genvar i = 0; i < LANES; i++) begin : g_steer
    assign lane_wdata[i] = wdata_left[31-8*i -: 8];
    assign lane_we[i]    = wr_commit && (3'(i) < acc_n);
  end

  ram_byte_array #(
    .ADDR_W     (ADDR_W)
  ) u_array (
    .clk        (clk),
    .base_addr  (acc_addr),
    .lane_we    (lane_we),
    .lane_wdata (lane_wdata),
    .lane_rdata (lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    size_d  = size_q;
    rd_d    = rd_q;
    dout_d  = dout_q;
    commit  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Enable) begin
          addr_d = Address;
          din_d  = DataIn[31:0];
          size_d = size_e'(mode[1:0]);
          rd_d   = ReadWrite;
          if (LATENCY <= 1) begin
            commit  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q <= 4'd1) begin
          commit  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (!Enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit && acc_rd) begin
      dout_d = acc_bad ? '0 : DATA_W'(rdata_just);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      size_q  <= SZ_BYTE;
      rd_q    <= 1'b1;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      size_q  <= size_d;
      rd_q    <= rd_d;
      dout_q  <= dout_d;
    end
  end

`ifdef RAM_ALIGN_FAULT_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if ((state_q == ST_IDLE) && Enable) begin
      misalign_d = 1'b0;
    end
    if (commit) begin
      misalign_d = acc_misalign;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign Misalign = misalign_q;
`endif

  assign DataOut = dout_q;
  // Combinational so MOC falls the instant the client releases Enable.
  assign MOC     = (state_q == ST_DONE) && Enable;

endmodule

`default_nettype wire

// File: tb/tb_ram_access.sv
// ============================================================================
//  Module : tb_ram_access
//  Brief  : Scoreboard bench for ram_access against a byte-array model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_access;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int LATENCY = 2;
  localparam int MDEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              Enable = 1'b0;
  logic              ReadWrite = 1'b1;
  logic [ADDR_W-1:0] Address = '0;
  logic [DATA_W-1:0] DataIn = '0;
  logic [3:0]        mode = '0;
  logic [DATA_W-1:0] DataOut;
  logic              MOC;
`ifdef RAM_ALIGN_FAULT_EN
  logic              Misalign;
`endif

  ram_access #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .LATENCY   (LATENCY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Enable    (Enable),
    .ReadWrite (ReadWrite),
    .Address   (Address),
    .DataIn    (DataIn),
    .mode      (mode),
    .DataOut   (DataOut),
`ifdef RAM_ALIGN_FAULT_EN
    .Misalign  (Misalign),
`endif
    .MOC       (MOC)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  model [MDEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_misaligned(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
`ifdef RAM_ALIGN_FAULT_EN
    return ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  // One handshake: drive, wait for MOC (bounded), check, hold, release.
  task automatic access(input logic rw, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                        input logic [3:0] m, input int hold, input string tag);
    int          n;
    int          lat;
    logic        mis;
    logic [31:0] e;
    logic [ADDR_W-1:0] ai;
    @(negedge clk);
    Enable = 1'b1; ReadWrite = rw; Address = a; DataIn = d; mode = m;
    n   = (m[1:0] == 2'b00) ? 1 : (m[1:0] == 2'b01) ? 2 : (m[1:0] == 2'b10) ? 4 : 0;
    mis = model_misaligned(a, m[1:0]);
    e   = '0;
    if (rw) begin
      if (n != 0 && !mis)
        for (int i = 0; i < n; i++) begin
          ai = a + ADDR_W'(i);
          e  = (e << 8) | {24'b0, model[ai]};
        end
      exp_q.push_back(e);
    end else if (n != 0 && !mis) begin
      for (int i = 0; i < n; i++) begin
        ai = a + ADDR_W'(i);
        model[ai] = d[8*(n-1-i) +: 8];
      end
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        // Inputs after accept must have no effect on the access in flight.
        Address = ADDR_W'($urandom); DataIn = $urandom; mode = 4'($urandom); ReadWrite = ~rw;
      end
    end while (!MOC && lat < 20);
    check({tag, " latency"}, lat, LATENCY);
    if (rw) begin
      e = exp_q.pop_front();
      check({tag, " rdata"}, DataOut, e);
      last_rd = e;
    end else begin
      check({tag, " dout kept"}, DataOut, last_rd);
    end
`ifdef RAM_ALIGN_FAULT_EN
    check({tag, " misalign"}, {31'b0, Misalign}, {31'b0, mis});
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " hold moc"}, {31'b0, MOC}, 32'd1);
      check({tag, " hold dout"}, DataOut, last_rd);
    end
    @(negedge clk);
    Enable = 1'b0;
    #1;
    check({tag, " moc drop"}, {31'b0, MOC}, 32'd0);
  endtask

  initial begin
    Enable = 1'b1;
    repeat (2) @(negedge clk);
    check("reset moc", {31'b0, MOC}, 32'd0);
    check("reset dout", DataOut, 32'd0);
`ifdef RAM_ALIGN_FAULT_EN
    check("reset misalign", {31'b0, Misalign}, 32'd0);
`endif
    Enable = 1'b0;
    rst_n  = 1'b1;

    for (int i = 0; i < MDEPTH; i++)
      access(1'b0, ADDR_W'(i), {24'b0, 8'(i * 7 + 3)}, 4'd0, 0, "preload");
    for (int i = 0; i < 8; i++)
      access(1'b0, ADDR_W'(i), {24'b0, 8'(8'h11 * (i + 1))}, 4'd0, 0, "pre8");

    access(1'b1, 9'd0, '0, 4'd2, 0, "word@0");
    access(1'b0, 9'd3, 32'h0000ABCD, 4'd1, 0, "half wr@3");
    access(1'b1, 9'd0, '0, 4'd2, 0, "word@0 b");
    access(1'b1, 9'd4, '0, 4'd0, 0, "byte@4");
    access(1'b0, 9'd510, 32'hDEADBEEF, 4'd2, 0, "word wr@510");
    access(1'b1, 9'd510, '0, 4'd0, 0, "byte@510");
    access(1'b1, 9'd511, '0, 4'd0, 0, "byte@511");
    access(1'b1, 9'd0, '0, 4'd0, 0, "byte@0");
    access(1'b1, 9'd1, '0, 4'd0, 0, "byte@1");
    access(1'b1, 9'd4, '0, 4'd2, 5, "hold rd");
    access(1'b1, 9'd5, '0, 4'b1101, 0, "half hi-mode");

    // Reset while a write is in flight: no write, outputs cleared.
    @(negedge clk);
    Enable = 1'b1; ReadWrite = 1'b0; Address = 9'd2; DataIn = 32'h5A; mode = 4'd0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort moc", {31'b0, MOC}, 32'd0);
    check("abort dout", DataOut, 32'd0);
    last_rd = '0;
    Enable  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 9'd2, '0, 4'd0, 0, "after abort");

    access(1'b1, 9'd0, '0, 4'd2, 0, "pre rsvd");
    access(1'b1, 9'd0, '0, 4'd3, 0, "rsvd rd");
    access(1'b0, 9'd0, 32'hFFFFFFFF, 4'd3, 0, "rsvd wr");
    access(1'b1, 9'd0, '0, 4'd2, 0, "post rsvd");
    access(1'b1, 9'd1, '0, 4'd2, 0, "word@1");

    for (int k = 0; k < 30; k++)
      access(1'($urandom), ADDR_W'($urandom), $urandom, 4'($urandom), 0, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
